// File: rtl/bist_signature_analyzer.sv
// ============================================================================
// Module      : bist_signature_analyzer
// Description : BIST response compactor. Builds a MISR signature from the CUT
//               response words, then compares it against GOLDEN and reports
//               PASS/FAIL. Optional macro SIG_COUNT_CHECK_EN adds the CAPT_CNT
//               port and makes PASS also require EXP_CNT captures.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bist_signature_analyzer #(
   parameter int         W       = 8,
   parameter logic [W-1:0] POLY  = 8'h1D,
   parameter logic [W-1:0] SEED  = 8'h00,
   parameter logic [W-1:0] GOLDEN = 8'h00,
   parameter int         EXP_CNT = 81
) (
   input  logic         CLK,
   input  logic         RESET_N,
   input  logic         RUNNING,
   input  logic         OUT,
   input  logic         BIST_END,
   input  logic [W-1:0] CUT_DATA,
   output logic [W-1:0] SIGNATURE,
   output logic         BUSY,
   output logic         DONE,
   output logic         PASS,
`ifdef SIG_COUNT_CHECK_EN
   output logic         FAIL,
   output logic [15:0]  CAPT_CNT
`else
   output logic         FAIL
`endif
);

   if (W < 2 || W > 32 || EXP_CNT < 1 || EXP_CNT > 65535) begin : g_param_check
      $error("bist_signature_analyzer: W must be 2..32 and EXP_CNT 1..65535");
   end

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COMPACT = 2'd1,
      ST_EVAL    = 2'd2,
      ST_RESULT  = 2'd3
   } state_t;

   state_t         state_q, state_d;
   logic [W-1:0]   sig_q, sig_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;
   logic           pass_q, pass_d;
   logic           fail_q, fail_d;
   logic [W-1:0]   misr_next;
   logic           result_ok;

`ifdef SIG_COUNT_CHECK_EN
   localparam logic [15:0] c_exp_cnt = 16'(EXP_CNT);
   logic [15:0]    cnt_q, cnt_d;
   logic [15:0]    cnt_inc;

   assign cnt_inc   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
   assign result_ok = (sig_q == GOLDEN) && (cnt_q == c_exp_cnt);
`else
   assign result_ok = (sig_q == GOLDEN);
`endif

   assign misr_next = {sig_q[W-2:0], 1'b0} ^ (sig_q[W-1] ? POLY : '0) ^ CUT_DATA;

   always_comb begin
      state_d = state_q;
      sig_d   = sig_q;
      done_d  = done_q;
      pass_d  = pass_q;
      fail_d  = fail_q;
`ifdef SIG_COUNT_CHECK_EN
      cnt_d   = cnt_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (RUNNING) begin
               state_d = ST_COMPACT;
               sig_d   = SEED;
`ifdef SIG_COUNT_CHECK_EN
               cnt_d   = 16'd0;
`endif
            end
         end
         ST_COMPACT: begin
            // A capture on the BIST_END edge is folded in before evaluation.
            if (OUT) begin
               sig_d = misr_next;
`ifdef SIG_COUNT_CHECK_EN
               cnt_d = cnt_inc;
`endif
            end
            if (BIST_END) begin
               state_d = ST_EVAL;
            end else if (!RUNNING) begin
               state_d = ST_IDLE;
               sig_d   = SEED;
`ifdef SIG_COUNT_CHECK_EN
               cnt_d   = 16'd0;
`endif
            end
         end
         ST_EVAL: begin
            state_d = ST_RESULT;
            done_d  = 1'b1;
            pass_d  = result_ok;
            fail_d  = ~result_ok;
         end
         ST_RESULT: begin
            if (RUNNING) begin
               state_d = ST_COMPACT;
               sig_d   = SEED;
               done_d  = 1'b0;
               pass_d  = 1'b0;
               fail_d  = 1'b0;
`ifdef SIG_COUNT_CHECK_EN
               cnt_d   = 16'd0;
`endif
            end
         end
         default: begin
            state_d = ST_IDLE;
            sig_d   = SEED;
            done_d  = 1'b0;
            pass_d  = 1'b0;
            fail_d  = 1'b0;
         end
      endcase
      busy_d = (state_d == ST_COMPACT) || (state_d == ST_EVAL);
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= ST_IDLE;
         sig_q   <= SEED;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         fail_q  <= 1'b0;
`ifdef SIG_COUNT_CHECK_EN
         cnt_q   <= 16'd0;
`endif
      end else begin
         state_q <= state_d;
         sig_q   <= sig_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         fail_q  <= fail_d;
`ifdef SIG_COUNT_CHECK_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   assign SIGNATURE = sig_q;
   assign BUSY      = busy_q;
   assign DONE      = done_q;
   assign PASS      = pass_q;
   assign FAIL      = fail_q;
`ifdef SIG_COUNT_CHECK_EN
   assign CAPT_CNT  = cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bist_signature_analyzer.sv
// ============================================================================
// Module      : tb_bist_signature_analyzer
// Description : Randomised scoreboard bench for bist_signature_analyzer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bist_signature_analyzer;

   localparam int         W       = 8;
   localparam logic [7:0] POLY    = 8'h1D;
   localparam logic [7:0] SEED    = 8'h00;
   localparam logic [7:0] GOLDEN  = 8'h5A;
   localparam int         EXP_CNT = 81;

   logic       CLK = 1'b0;
   logic       RESET_N = 1'b0;
   logic       RUNNING = 1'b0;
   logic       OUT = 1'b0;
   logic       BIST_END = 1'b0;
   logic [7:0] CUT_DATA = 8'h00;
   logic [7:0] SIGNATURE;
   logic       BUSY, DONE, PASS, FAIL;
`ifdef SIG_COUNT_CHECK_EN
   logic [15:0] CAPT_CNT;
`endif

   bist_signature_analyzer #(
      .W(W), .POLY(POLY), .SEED(SEED), .GOLDEN(GOLDEN), .EXP_CNT(EXP_CNT)
   ) dut (
      .CLK(CLK), .RESET_N(RESET_N), .RUNNING(RUNNING), .OUT(OUT),
      .BIST_END(BIST_END), .CUT_DATA(CUT_DATA), .SIGNATURE(SIGNATURE),
      .BUSY(BUSY), .DONE(DONE), .PASS(PASS),
`ifdef SIG_COUNT_CHECK_EN
      .FAIL(FAIL), .CAPT_CNT(CAPT_CNT)
`else
      .FAIL(FAIL)
`endif
   );

   always #5 CLK = ~CLK;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   always @(posedge CLK) cyc++;

   typedef struct {
      logic [7:0] sig;
      logic       pass;
      int         cnt;
      int         cyc;
   } exp_t;
   exp_t sb_q[$];
   exp_t mon_e;

   function automatic void check(string name, longint act, longint req);
      n_cmp++;
      if (act != req) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endfunction

   // Reference: multiply signature by x modulo the feedback polynomial, add data.
   function automatic logic [7:0] mstep(logic [7:0] s, logic [7:0] d);
      int v;
      v = int'(s) * 2;
      if (v >= 256) v = (v - 256) ^ int'(POLY);
      return 8'(v) ^ d;
   endfunction

   logic [7:0] m_sig;
   int         m_cnt;
   logic [7:0] stream [81];

   // Monitor: whenever DONE rises, pop the next expected result and compare.
   logic done_prev = 1'b0;
   always @(negedge CLK) begin
      if (DONE && !done_prev) begin
         if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_done: got DONE=1, expected no result pending");
         end else begin
            mon_e = sb_q.pop_front();
            check("done_latency", cyc, mon_e.cyc);
            check("result_sig", SIGNATURE, mon_e.sig);
            check("result_pass", PASS, mon_e.pass);
            check("result_fail", FAIL, !mon_e.pass);
`ifdef SIG_COUNT_CHECK_EN
            check("capt_cnt", CAPT_CNT, mon_e.cnt);
`endif
         end
      end
      done_prev = DONE;
   end

   task automatic drive(input logic r, input logic o, input logic b, input logic [7:0] d);
      RUNNING  = r;
      OUT      = o;
      BIST_END = b;
      CUT_DATA = d;
      @(negedge CLK);
   endtask

   task automatic start_run();
      drive(1'b1, 1'b0, 1'b0, 8'(($urandom)));
      m_sig = SEED;
      m_cnt = 0;
   endtask

   task automatic capture(input logic [7:0] d);
      m_sig = mstep(m_sig, d);
      m_cnt++;
      drive(1'b1, 1'b1, 1'b0, d);
   endtask

   task automatic gap();
      if ($urandom_range(0, 3) == 0) drive(1'b1, 1'b0, 1'b0, 8'($urandom));
   endtask

   // Random stream of n words whose last word steers the signature onto GOLDEN.
   task automatic gen_stream(input int n);
      logic [7:0] s;
      s = SEED;
      for (int i = 0; i < n - 1; i++) begin
         stream[i] = 8'($urandom);
         s = mstep(s, stream[i]);
      end
      stream[n-1] = GOLDEN ^ mstep(s, 8'h00);
   endtask

   task automatic finish_run(input logic cap, input logic [7:0] d);
      exp_t e;
      int   k;
      if (cap) begin
         m_sig = mstep(m_sig, d);
         m_cnt++;
      end
      e.sig  = m_sig;
`ifdef SIG_COUNT_CHECK_EN
      e.pass = (m_sig == GOLDEN) && (m_cnt == EXP_CNT);
`else
      e.pass = (m_sig == GOLDEN);
`endif
      e.cnt  = m_cnt;
      e.cyc  = cyc + 2;
      sb_q.push_back(e);
      drive(1'b0, cap, 1'b1, d);
      OUT      = 1'b0;
      BIST_END = 1'b0;
      k = 0;
      while (sb_q.size() != 0 && k < 8) begin
         @(negedge CLK);
         k++;
      end
      if (sb_q.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL done_timeout: got no DONE within 8 cycles, expected DONE");
         sb_q.delete();
      end
   endtask

   task automatic run_stream(input int n, input int flip_idx, input logic [7:0] mask,
                             input logic end_cap);
      logic [7:0] d;
      for (int i = 0; i < n; i++) begin
         gap();
         d = stream[i] ^ ((i == flip_idx) ? mask : 8'h00);
         if (end_cap && i == n - 1) begin
            finish_run(1'b1, d);
         end else begin
            capture(d);
            check("misr_step", SIGNATURE, m_sig);
         end
      end
      if (!end_cap) begin
         gap();
         finish_run(1'b0, 8'h00);
      end
   endtask

   task automatic check_reset_outputs(input string name);
      check(name, {SIGNATURE, BUSY, DONE, PASS, FAIL}, {SEED, 4'b0000});
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion, expected finish before 500us");
      $fatal(1, "watchdog expired");
   end

   initial begin
      #12;
      check_reset_outputs("reset_state");
      RESET_N = 1'b1;
      @(negedge CLK);

      // Single step: OUT on the entry edge is ignored, then A5 and 00.
      drive(1'b1, 1'b1, 1'b0, 8'hFF);
      m_sig = SEED;
      m_cnt = 0;
      check("entry_busy", BUSY, 1);
      check("entry_out_ignored", SIGNATURE, SEED);
      capture(8'hA5);
      check("step_a5", SIGNATURE, 8'hA5);
      capture(8'h00);
      check("step_57", SIGNATURE, 8'h57);
      drive(1'b0, 1'b0, 1'b0, 8'h00);
      check("abort1", {BUSY, DONE, SIGNATURE}, {2'b00, SEED});
      drive(1'b0, 1'b1, 1'b1, 8'h33);
      check("idle_ignores_end", {BUSY, DONE, SIGNATURE}, {2'b00, SEED});

      // Full passing run.
      gen_stream(81);
      start_run();
      run_stream(81, -1, 8'h00, 1'b0);
      drive(1'b0, 1'b1, 1'b1, 8'($urandom));
      check("result_hold", {DONE, PASS, FAIL, SIGNATURE}, {3'b110, GOLDEN});

      // Same stream with one flipped bit in capture 40; final OUT on the BIST_END edge.
      start_run();
      check("restart_clear", {DONE, PASS, FAIL, SIGNATURE}, {3'b000, SEED});
      run_stream(81, 40, 8'(1 << $urandom_range(0, 7)), 1'b1);
      check("flip_sig_ne_golden", (SIGNATURE != GOLDEN), 1);
      check("flip_fail", {DONE, FAIL}, 2'b11);

      // Abort after 10 captures.
      start_run();
      for (int i = 0; i < 10; i++) capture(8'($urandom));
      check("pre_abort_sig", SIGNATURE, m_sig);
      drive(1'b0, 1'b0, 1'b0, 8'h00);
      check("abort_state", {BUSY, DONE, SIGNATURE}, {2'b00, SEED});
      drive(1'b0, 1'b0, 1'b0, 8'h00);
      check("abort_stays_idle", {BUSY, DONE}, 2'b00);

      // 80 captures reaching GOLDEN: count check decides the verdict.
      gen_stream(80);
      start_run();
      run_stream(80, -1, 8'h00, 1'b0);

      // Asynchronous reset in the middle of compaction.
      start_run();
      for (int i = 0; i < 5; i++) capture(8'($urandom));
      #2 RESET_N = 1'b0;
      RUNNING = 1'b0;
      OUT = 1'b0;
      #1 check_reset_outputs("async_reset_compact");
      @(negedge CLK);
      #2 RESET_N = 1'b1;
      @(negedge CLK);

      // Passing run, then asynchronous reset out of RESULT.
      gen_stream(81);
      start_run();
      run_stream(81, -1, 8'h00, 1'b0);
      #2 RESET_N = 1'b0;
      #1 check_reset_outputs("async_reset_result");
      @(negedge CLK);
      #2 RESET_N = 1'b1;
      @(negedge CLK);

      // Fresh run after reset.
      gen_stream(81);
      start_run();
      run_stream(81, -1, 8'h00, 1'b1);
      check("final_pass", {DONE, PASS, SIGNATURE}, {2'b11, GOLDEN});

      repeat (3) @(negedge CLK);
      check("scoreboard_empty", sb_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
